// File: rtl/vc_icache_if.sv
// Fetch-side bundle between the CPU/QSPI controller and vc_icache.
interface vc_icache_if #(
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 4
);
  localparam int OB = $clog2(LINE_LENGTH);

  logic [PA-1:0]    paddr;
  logic             fault;
  logic             flush;
  logic [3:0]       dread;
  logic             wstrobe_d;
  logic             hit;
  logic             pull;
  logic [PA-OB-1:0] tag;
  logic [15:0]      rdata;

  modport master (
    output paddr, fault, flush, dread, wstrobe_d,
    input  hit, pull, tag, rdata
  );

  modport slave (
    input  paddr, fault, flush, dread, wstrobe_d,
    output hit, pull, tag, rdata
  );
endinterface

// File: rtl/vc_icache.sv
// Direct-mapped flop-based instruction cache. Lines are filled one nibble per
// strobe from a transfer owned by the external QSPI controller.
module vc_icache #(
  parameter int PA          = 22,
  parameter int RV          = 16,
  parameter int LINE_LENGTH = 4,
  parameter int NLINES      = 4
) (
  input  logic       clk,
  input  logic       reset,
  vc_icache_if.slave bus
);
  localparam int OB = $clog2(LINE_LENGTH);
  localparam int IB = $clog2(NLINES);
  localparam int TW = PA - OB - IB;
  localparam int NN = 2 * LINE_LENGTH;
  localparam int CW = $clog2(NN);

  logic [NLINES-1:0][NN-1:0][3:0] data_q, data_d;
  logic [NLINES-1:0][TW-1:0]      tagreg_q, tagreg_d;
  logic [NLINES-1:0]              valid_q, valid_d;
  logic [IB-1:0]                  fill_idx_q, fill_idx_d;
  logic [CW-1:0]                  cnt_q, cnt_d;

  logic [IB-1:0] idx_s;
  logic [TW-1:0] ptag_s;
  logic [OB-1:0] off_s;
  logic [CW-1:0] nib_base_s;
  logic [IB-1:0] wr_idx_s;
  logic          hit_s;
  logic [RV-1:0] rdata_s;

  assign idx_s  = bus.paddr[OB+IB-1:OB];
  assign ptag_s = bus.paddr[PA-1:OB+IB];
  assign off_s  = bus.paddr[OB-1:0];

  // Nibble slot of the even byte of the addressed halfword; paddr[0] drops out.
  assign nib_base_s = {off_s, 1'b0} & ~CW'(2'd3);

  assign hit_s = !reset && valid_q[idx_s] && (tagreg_q[idx_s] == ptag_s);

  // Each byte is stored high nibble first, so the low byte sits in slots base/base+1.
  assign rdata_s = {data_q[idx_s][nib_base_s + CW'(2'd2)],
                    data_q[idx_s][nib_base_s + CW'(2'd3)],
                    data_q[idx_s][nib_base_s],
                    data_q[idx_s][nib_base_s + CW'(2'd1)]};

  assign bus.hit   = hit_s;
  assign bus.pull  = !hit_s && !bus.fault && !reset;
  assign bus.tag   = bus.paddr[PA-1:OB];
  assign bus.rdata = rdata_s;

  // Fill bookkeeping: abort, first-strobe latch, nibble store and line commit.
  always_comb begin
    data_d     = data_q;
    tagreg_d   = tagreg_q;
    valid_d    = valid_q;
    fill_idx_d = fill_idx_q;
    cnt_d      = cnt_q;
    wr_idx_s   = fill_idx_q;
    if (bus.flush || bus.fault) begin
      cnt_d = '0;
      if (bus.flush) begin
        valid_d = '0;
      end else begin
        valid_d = valid_q;
      end
    end else if (bus.wstrobe_d) begin
      if (cnt_q == '0) begin
        wr_idx_s         = idx_s;
        fill_idx_d       = idx_s;
        tagreg_d[idx_s]  = ptag_s;
        valid_d[idx_s]   = 1'b0;
      end else begin
        wr_idx_s = fill_idx_q;
      end
      data_d[wr_idx_s][cnt_q] = bus.dread;
      if (cnt_q == CW'(NN - 1)) begin
        valid_d[wr_idx_s] = 1'b1;
        cnt_d             = '0;
      end else begin
        cnt_d = cnt_q + CW'(1'b1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control state: valid bits and nibble counter, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload state: data, tags and fill index are only meaningful behind a valid bit.
  always_ff @(posedge clk) begin
    data_q     <= data_d;
    tagreg_q   <= tagreg_d;
    fill_idx_q <= fill_idx_d;
  end
endmodule

// File: tb/tb_vc_icache.sv
// Randomized and directed bench for vc_icache against a byte-level line model.
module tb_vc_icache;
  localparam int PA = 22;
  localparam int LL = 4;
  localparam int NL = 4;
  localparam int NN = 2 * LL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;

  bit         m_valid [NL];
  int         m_tag   [NL];
  logic [7:0] m_byte  [NL][LL];
  int         m_cnt;
  int         m_fidx;

  logic        obs_hit;
  logic        obs_pull;
  logic [15:0] obs_rdata;

  always #5 clk = ~clk;

  vc_icache_if #(.PA(PA), .LINE_LENGTH(LL)) bus ();

  vc_icache #(.PA(PA), .RV(16), .LINE_LENGTH(LL), .NLINES(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs against the model, then advance the model.
  task automatic drive(input logic [PA-1:0] pa, input logic f, input logic fl,
                       input logic st, input logic [3:0] nib, input logic r);
    int   idx;
    int   ptag;
    int   k;
    logic e_hit;
    @(negedge clk);
    bus.paddr     = pa;
    bus.fault     = f;
    bus.flush     = fl;
    bus.wstrobe_d = st;
    bus.dread     = nib;
    reset         = r;
    #1;
    idx   = (int'(pa) / LL) % NL;
    ptag  = int'(pa) / (LL * NL);
    k     = (int'(pa) % LL) & ~1;
    e_hit = !r && m_valid[idx] && (m_tag[idx] == ptag);
    obs_hit   = bus.hit;
    obs_pull  = bus.pull;
    obs_rdata = bus.rdata;
    chk("hit", bus.hit, e_hit);
    chk("pull", bus.pull, !e_hit && !f && !r);
    chk("tag", bus.tag, int'(pa) / LL);
    if (e_hit) chk("rdata", bus.rdata, {m_byte[idx][k+1], m_byte[idx][k]});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
      m_cnt = 0;
    end else if (fl || f) begin
      m_cnt = 0;
      if (fl) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    end else if (st) begin
      if (m_cnt == 0) begin
        m_fidx       = idx;
        m_tag[idx]   = ptag;
        m_valid[idx] = 1'b0;
      end
      if (m_cnt % 2 == 0) m_byte[m_fidx][m_cnt/2][7:4] = nib;
      else                m_byte[m_fidx][m_cnt/2][3:0] = nib;
      m_cnt++;
      if (m_cnt == NN) begin
        m_valid[m_fidx] = 1'b1;
        m_cnt           = 0;
      end
    end
  endtask

  task automatic fill(input logic [PA-1:0] pa, input logic [31:0] nibs);
    for (int n = 0; n < NN; n++) drive(pa, 1'b0, 1'b0, 1'b1, nibs[31-4*n -: 4], 1'b0);
  endtask

  task automatic idle(input logic [PA-1:0] pa);
    drive(pa, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    logic [PA-1:0] pa;
    int            roll;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      for (int j = 0; j < LL; j++) m_byte[i][j] = 8'h00;
    end
    m_cnt = 0;
    m_fidx = 0;
    bus.paddr = '0; bus.fault = 1'b0; bus.flush = 1'b0; bus.dread = 4'h0; bus.wstrobe_d = 1'b0;

    drive(22'h000100, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    chk("rst_hit", obs_hit, 1'b0);
    chk("rst_pull", obs_pull, 1'b0);
    drive(22'h000100, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    idle(22'h000100);
    chk("miss_hit", obs_hit, 1'b0);
    chk("miss_pull", obs_pull, 1'b1);

    fill(22'h000100, 32'h34127856);
    idle(22'h000100);
    chk("fill_hit", obs_hit, 1'b1);
    chk("fill_rd0", obs_rdata, 16'h1234);
    idle(22'h000102);
    chk("fill_rd1", obs_rdata, 16'h5678);

    fill(22'h000110, 32'hABCDEF01);
    idle(22'h000100);
    chk("conf_old_hit", obs_hit, 1'b0);
    chk("conf_old_pull", obs_pull, 1'b1);
    idle(22'h000110);
    chk("conf_new_hit", obs_hit, 1'b1);

    fill(22'h000100, 32'h34127856);
    fill(22'h000104, 32'hCAFEBABE);
    idle(22'h000100);
    chk("two_rd0", obs_rdata, 16'h1234);
    idle(22'h000104);
    chk("two_hit1", obs_hit, 1'b1);
    chk("two_rd1", obs_rdata, 16'hFECA);
    idle(22'h000106);
    chk("two_rd2", obs_rdata, 16'hBEBA);

    for (int n = 0; n < 5; n++) drive(22'h000108, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
    drive(22'h000108, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0);
    idle(22'h000108);
    chk("fault_hit", obs_hit, 1'b0);
    fill(22'h000108, 32'h11223344);
    idle(22'h000108);
    chk("refill_hit", obs_hit, 1'b1);
    chk("refill_rd", obs_rdata, 16'h2211);

    fill(22'h00010C, 32'h99AABBCC);
    idle(22'h00010C);
    chk("four_hit", obs_hit, 1'b1);
    drive(22'h000100, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    for (int a = 0; a < NL; a++) begin
      idle(22'h000100 + 22'(4 * a));
      chk("flush_miss", obs_hit, 1'b0);
    end
    for (int n = 0; n < NN - 1; n++) drive(22'h000100, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0);
    drive(22'h000100, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0);
    idle(22'h000100);
    chk("flush_last", obs_hit, 1'b0);

    for (int n = 0; n < 3; n++) drive(22'h000104, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
    drive(22'h000104, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1);
    chk("midrst_hit", obs_hit, 1'b0);
    fill(22'h000104, 32'h55667788);
    idle(22'h000104);
    chk("postrst_hit", obs_hit, 1'b1);
    chk("postrst_rd", obs_rdata, 16'h6655);

    // Random traffic over three tags sharing the four indices.
    pa = 22'h000100;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 30)
        pa = 22'h000100 + 22'($urandom_range(0, 2) * 16 + $urandom_range(0, 15));
      roll = $urandom_range(0, 199);
      drive(pa, roll < 5, (roll >= 5) && (roll < 8), $urandom_range(0, 99) < 60,
            4'($urandom), roll == 199);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
